// File: rtl/arcade_input_ctrl.sv
// Input front end for the phoenix core: PS/2 key events and two joysticks become
// registered button levels, and coin requests become fixed-width coin pulses.
module arcade_input_ctrl #(
  parameter int COIN_PULSE = 1100000,
  parameter int COIN_GAP   = 1100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        no_rotate,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_fire,
  output logic        btn_barrier,
  output logic [1:0]  btn_player_start,
  output logic        btn_coin
);

  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_t;

  logic ps2_toggle_r;
  logic key_up_r, key_down_r, key_left_r, key_right_r, key_barrier_r, key_fire_r;
  logic key_f1_r, key_f2_r, key_start1b_r, key_start2b_r, key_coin1_r, key_coin2_r;
  logic key_up2_r, key_down2_r, key_left2_r, key_right2_r, key_fire2_r, key_barrier2_r;
  logic key_event_s, key_pressed_s, key_ext_s;
  logic [15:0] joy_s;
  logic left_s, right_s, fire_s, barrier_s;
  logic [1:0] start_s;
  logic coin_src_s, coin_src_r, coin_src_d_r, coin_req_s;
  coin_state_t state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic pending_r, pending_nxt_s;
  logic unused_s;

  assign key_event_s   = ps2_key[10] ^ ps2_toggle_r;
  assign key_pressed_s = ps2_key[9];
  assign key_ext_s     = ps2_key[8];
  assign joy_s         = joystick_0 | joystick_1;
  assign unused_s      = ^joy_s[15:9];

  assign left_s    = no_rotate ? (key_down_r | key_down2_r | joy_s[2])
                               : (key_left_r | key_left2_r | joy_s[1]);
  assign right_s   = no_rotate ? (key_up_r | key_up2_r | joy_s[3])
                               : (key_right_r | key_right2_r | joy_s[0]);
  assign fire_s    = key_fire_r | key_fire2_r | joy_s[4];
  assign barrier_s = key_barrier_r | key_barrier2_r | joy_s[5];
  assign start_s   = {key_f2_r | key_start2b_r | joy_s[7],
                      key_f1_r | key_start1b_r | joy_s[6]};
  assign coin_src_s = key_coin1_r | key_coin2_r | joy_s[8] | start_s[0] | start_s[1];
  assign coin_req_s = coin_src_r & ~coin_src_d_r;

  // Key event detection and per-key pressed state; unmatched codes leave state untouched
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_toggle_r  <= 1'b0;
      key_up_r      <= 1'b0; key_down_r    <= 1'b0; key_left_r     <= 1'b0;
      key_right_r   <= 1'b0; key_barrier_r <= 1'b0; key_fire_r     <= 1'b0;
      key_f1_r      <= 1'b0; key_f2_r      <= 1'b0; key_start1b_r  <= 1'b0;
      key_start2b_r <= 1'b0; key_coin1_r   <= 1'b0; key_coin2_r    <= 1'b0;
      key_up2_r     <= 1'b0; key_down2_r   <= 1'b0; key_left2_r    <= 1'b0;
      key_right2_r  <= 1'b0; key_fire2_r   <= 1'b0; key_barrier2_r <= 1'b0;
    end else begin
      ps2_toggle_r <= ps2_key[10];
      if (key_event_s) begin
        case (ps2_key[7:0])
          8'h75: key_up_r      <= key_pressed_s;
          8'h72: key_down_r    <= key_pressed_s;
          8'h6B: key_left_r    <= key_pressed_s;
          8'h74: key_right_r   <= key_pressed_s;
          8'h14: key_barrier_r <= key_pressed_s;
          default: begin
            if (!key_ext_s) begin
              case (ps2_key[7:0])
                8'h29: key_fire_r     <= key_pressed_s;
                8'h05: key_f1_r       <= key_pressed_s;
                8'h06: key_f2_r       <= key_pressed_s;
                8'h16: key_start1b_r  <= key_pressed_s;
                8'h1E: key_start2b_r  <= key_pressed_s;
                8'h2E: key_coin1_r    <= key_pressed_s;
                8'h36: key_coin2_r    <= key_pressed_s;
                8'h2D: key_up2_r      <= key_pressed_s;
                8'h2B: key_down2_r    <= key_pressed_s;
                8'h23: key_left2_r    <= key_pressed_s;
                8'h34: key_right2_r   <= key_pressed_s;
                8'h1C: key_fire2_r    <= key_pressed_s;
                8'h1B: key_barrier2_r <= key_pressed_s;
                default: begin end
              endcase
            end
          end
        endcase
      end
    end
  end

  // Coin source history resets high so a source still held across reset cannot fire a pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_left         <= 1'b0;
      btn_right        <= 1'b0;
      btn_fire         <= 1'b0;
      btn_barrier      <= 1'b0;
      btn_player_start <= 2'b00;
      btn_coin         <= 1'b0;
      coin_src_r       <= 1'b1;
      coin_src_d_r     <= 1'b1;
      state_r          <= ST_IDLE;
      cnt_r            <= '0;
      pending_r        <= 1'b0;
    end else begin
      btn_left         <= left_s;
      btn_right        <= right_s;
      btn_fire         <= fire_s;
      btn_barrier      <= barrier_s;
      btn_player_start <= start_s;
      btn_coin         <= (state_nxt_s == ST_PULSE);
      coin_src_r       <= coin_src_s;
      coin_src_d_r     <= coin_src_r;
      state_r          <= state_nxt_s;
      cnt_r            <= cnt_nxt_s;
      pending_r        <= pending_nxt_s;
    end
  end

  // Coin pulse sequencer; a request at GAP expiry chains straight into the next pulse
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pending_nxt_s = pending_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (coin_req_s) begin
          state_nxt_s = ST_PULSE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (coin_req_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
        if (cnt_r == PULSE_LAST) begin
          state_nxt_s = ST_GAP;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_nxt_s = '0;
          if (pending_r || coin_req_s) begin
            state_nxt_s   = ST_PULSE;
            pending_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (coin_req_s) begin
            pending_nxt_s = 1'b1;
          end else begin
            pending_nxt_s = pending_r;
          end
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = '0;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl: a vector table for the button mapping and
// hand-written windows for coin pulse shaping and reset behaviour.
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        no_rotate;
  logic        btn_left, btn_right, btn_fire, btn_barrier, btn_coin;
  logic [1:0]  btn_player_start;
  logic [5:0]  outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  assign outs = {btn_left, btn_right, btn_fire, btn_barrier, btn_player_start};

  arcade_input_ctrl #(.COIN_PULSE(4), .COIN_GAP(3)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ps2_key          (ps2_key),
    .joystick_0       (joystick_0),
    .joystick_1       (joystick_1),
    .no_rotate        (no_rotate),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_fire         (btn_fire),
    .btn_barrier      (btn_barrier),
    .btn_player_start (btn_player_start),
    .btn_coin         (btn_coin)
  );

  typedef struct packed {
    logic        key_ev;
    logic        pressed;
    logic        ext;
    logic [7:0]  code;
    logic        nr;
    logic [15:0] j0;
    logic [15:0] j1;
    logic [5:0]  exp;
    logic [1:0]  lat;
  } vec_t;

  localparam int NV = 39;
  localparam logic [5:0] L  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] F  = 6'b001000;
  localparam logic [5:0] B  = 6'b000100;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] Z  = 6'b000000;

  vec_t vecs [0:NV-1];

  function automatic vec_t kv(input logic p, input logic e, input logic [7:0] c,
                              input logic nr, input logic [5:0] x);
    vec_t v;
    v = '{key_ev: 1'b1, pressed: p, ext: e, code: c, nr: nr,
          j0: 16'h0000, j1: 16'h0000, exp: x, lat: 2'd2};
    return v;
  endfunction

  function automatic vec_t jv(input logic nr, input logic [15:0] a, input logic [15:0] b,
                              input logic [5:0] x);
    vec_t v;
    v = '{key_ev: 1'b0, pressed: 1'b0, ext: 1'b0, code: 8'h00, nr: nr,
          j0: a, j1: b, exp: x, lat: 2'd1};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic p, input logic e, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, e, c};
  endtask

  task automatic idle(input int n);
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0000;
    repeat (n) @(negedge clk_sys);
  endtask

  // stim[k] drives joystick_0[8] from negedge k; got[k] is btn_coin after posedge k
  task automatic run_coin(input logic [31:0] stim, output logic [31:0] got);
    got = 32'h0;
    got[0] = btn_coin;
    for (int k = 0; k < 24; k++) begin
      joystick_0[8] = stim[k];
      @(posedge clk_sys);
      @(negedge clk_sys);
      got[k+1] = btn_coin;
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [5:0]  prev_exp;

    vecs[0]  = kv(1'b1, 1'b1, 8'h6B, 1'b0, L);
    vecs[1]  = kv(1'b0, 1'b1, 8'h6B, 1'b0, Z);
    vecs[2]  = kv(1'b1, 1'b0, 8'h6B, 1'b0, L);
    vecs[3]  = kv(1'b0, 1'b0, 8'h6B, 1'b0, Z);
    vecs[4]  = jv(1'b1, 16'h0000, 16'h0004, L);
    vecs[5]  = jv(1'b1, 16'h0000, 16'h0002, Z);
    vecs[6]  = jv(1'b0, 16'h0000, 16'h0002, L);
    vecs[7]  = jv(1'b0, 16'h0001, 16'h0000, R);
    vecs[8]  = jv(1'b1, 16'h0008, 16'h0000, R);
    vecs[9]  = jv(1'b0, 16'h0000, 16'h0000, Z);
    vecs[10] = kv(1'b1, 1'b1, 8'h29, 1'b0, Z);
    vecs[11] = kv(1'b1, 1'b0, 8'h29, 1'b0, F);
    vecs[12] = kv(1'b1, 1'b0, 8'h55, 1'b0, F);
    vecs[13] = kv(1'b0, 1'b0, 8'h29, 1'b0, Z);
    vecs[14] = kv(1'b1, 1'b1, 8'h14, 1'b0, B);
    vecs[15] = kv(1'b0, 1'b0, 8'h14, 1'b0, Z);
    vecs[16] = kv(1'b1, 1'b0, 8'h05, 1'b0, S1);
    vecs[17] = kv(1'b0, 1'b0, 8'h05, 1'b0, Z);
    vecs[18] = kv(1'b1, 1'b0, 8'h1E, 1'b0, S2);
    vecs[19] = kv(1'b0, 1'b0, 8'h1E, 1'b0, Z);
    vecs[20] = kv(1'b1, 1'b1, 8'h75, 1'b1, R);
    vecs[21] = jv(1'b0, 16'h0000, 16'h0000, Z);
    vecs[22] = kv(1'b0, 1'b1, 8'h75, 1'b0, Z);
    vecs[23] = kv(1'b1, 1'b0, 8'h23, 1'b0, L);
    vecs[24] = kv(1'b0, 1'b0, 8'h23, 1'b0, Z);
    vecs[25] = kv(1'b1, 1'b0, 8'h2D, 1'b1, R);
    vecs[26] = kv(1'b0, 1'b0, 8'h2D, 1'b1, Z);
    vecs[27] = kv(1'b1, 1'b1, 8'h72, 1'b1, L);
    vecs[28] = kv(1'b0, 1'b1, 8'h72, 1'b1, Z);
    vecs[29] = jv(1'b0, 16'h0010, 16'h0020, F | B);
    vecs[30] = jv(1'b0, 16'h0040, 16'h0080, S1 | S2);
    vecs[31] = jv(1'b0, 16'h0000, 16'h0000, Z);
    vecs[32] = kv(1'b1, 1'b0, 8'h1B, 1'b0, B);
    vecs[33] = kv(1'b0, 1'b0, 8'h1B, 1'b0, Z);
    vecs[34] = kv(1'b1, 1'b1, 8'h06, 1'b0, Z);
    vecs[35] = kv(1'b1, 1'b0, 8'h1C, 1'b0, F);
    vecs[36] = kv(1'b0, 1'b0, 8'h1C, 1'b0, Z);
    vecs[37] = kv(1'b1, 1'b0, 8'h34, 1'b0, R);
    vecs[38] = kv(1'b0, 1'b0, 8'h34, 1'b0, Z);

    reset_n    = 1'b0;
    ps2_key    = 11'h000;
    joystick_0 = 16'h01FF;
    joystick_1 = 16'h0000;
    no_rotate  = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_outs", 32'({outs, btn_coin}), 32'h0);
    joystick_0 = 16'h0000;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("post_reset_outs", 32'({outs, btn_coin}), 32'h0);

    prev_exp = Z;
    for (int i = 0; i < NV; i++) begin
      no_rotate  = vecs[i].nr;
      joystick_0 = vecs[i].j0;
      joystick_1 = vecs[i].j1;
      if (vecs[i].key_ev) send_key(vecs[i].pressed, vecs[i].ext, vecs[i].code);
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (vecs[i].lat == 2'd2) begin
        check($sformatf("vec%0d_early", i), 32'(outs), 32'(prev_exp));
        @(posedge clk_sys);
        @(negedge clk_sys);
      end
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
      prev_exp = vecs[i].exp;
    end

    idle(12);
    run_coin(32'h0000_0001, got);
    check("coin_single", got, 32'h0000_003C);
    idle(12);
    run_coin(32'h00FF_FFFF, got);
    check("coin_held", got, 32'h0000_003C);
    idle(12);
    run_coin(32'h0000_0015, got);
    check("coin_pending_drop", got, 32'h0000_1E3C);
    idle(12);
    run_coin(32'h0000_0081, got);
    check("coin_at_gap_expiry", got, 32'h0000_1E3C);
    idle(12);
    send_key(1'b1, 1'b0, 8'h2E);
    run_coin(32'h0000_0000, got);
    check("coin_key_held", got, 32'h0000_0078);
    send_key(1'b0, 1'b0, 8'h2E);
    idle(12);

    joystick_0[8] = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("coin_before_reset", 32'(btn_coin), 32'h1);
    reset_n = 1'b0;
    #1;
    check("coin_async_drop", 32'(btn_coin), 32'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    run_coin(32'hFFFF_FFFF, got);
    check("coin_after_reset_held", got, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arcade_input_ctrl.md
ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Sits upstream of the phoenix core. Turns PS/2 key events and the two joysticks into the core's button inputs, and shapes coin pulses.

Interface
- REQ-001 Parameter COIN_PULSE, default 1100000: btn_coin high time in clk_sys cycles (100 ms at 11 MHz).
- REQ-002 Parameter COIN_GAP, default 1100000: minimum btn_coin low time between pulses, in clk_sys cycles.
- REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
- REQ-004 reset_n  in  1  asynchronous, active-low reset.
- REQ-005 ps2_key  in  11  [10] toggles once per key event; [9] pressed; [8] extended flag; [7:0] scan code.
- REQ-006 joystick_0, joystick_1  in  16 each  bits 0 right, 1 left, 2 down, 3 up, 4 fire, 5 barrier, 6 start1, 7 start2, 8 coin.
- REQ-007 no_rotate  in  1  1 = horizontal-screen control remap.
- REQ-008 btn_left, btn_right, btn_fire, btn_barrier  out  1 each  registered, active-high.
- REQ-009 btn_player_start  out  2  [0] player 1, [1] player 2; registered.
- REQ-010 btn_coin  out  1  shaped coin pulse; registered.

Function
- REQ-011 A key event is detected when ps2_key[10] differs from its value registered on the previous cycle; the toggle register resets to 0.
- REQ-012 On an event, the matched key state register loads ps2_key[9]; unmatched codes change no state.
- REQ-013 Keys matched with ps2_key[8] ignored: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x14 barrier (ctrl).
- REQ-014 Keys matched only with ps2_key[8]=0:
  - 0x29 fire; 0x05 F1 start1; 0x06 F2 start2; 0x16 start1b; 0x1E start2b; 0x2E coin1; 0x36 coin2.
  - Player 2: 0x2D up2, 0x2B down2, 0x23 left2, 0x34 right2, 0x1C fire2, 0x1B barrier2.
- REQ-015 With J = joystick_0 | joystick_1 (bitwise OR):
  - no_rotate=0: left = left | left2 | J[1]; right = right | right2 | J[0].
  - no_rotate=1: left = down | down2 | J[2]; right = up | up2 | J[3].
- REQ-016 Direct mappings:
  - fire = fire | fire2 | J[4]; barrier = barrier | barrier2 | J[5].
  - start[0] = F1 | start1b | J[6]; start[1] = F2 | start2b | J[7].
- REQ-017 Outputs of REQ-015/016 are registered: one clk_sys cycle from a key-state or joystick change to the output; two cycles from a ps2_key toggle.
- REQ-018 coin_src = coin1 | coin2 | J[8] | F1 | start1b | J[6] | F2 | start2b | J[7]. A coin request is a 0->1 transition of the registered coin_src.
- REQ-019 Coin FSM states and behaviour:
  - IDLE: btn_coin=0. A request enters PULSE with the counter cleared.
  - PULSE: btn_coin=1 for exactly COIN_PULSE cycles, then GAP.
  - GAP: btn_coin=0 for exactly COIN_GAP cycles, then IDLE, or directly PULSE if a request is pending (pending is then cleared).
- REQ-020 A request arriving in PULSE or GAP sets a single pending flag; further requests while pending is set are dropped.
- REQ-021 Holding coin_src high generates only one pulse; a new request needs coin_src to return to 0.
- REQ-022 A request in the same cycle GAP expires is treated as pending, so PULSE follows with no IDLE cycle.
- REQ-023 The counter is wide enough for max(COIN_PULSE, COIN_GAP) and never wraps; it clears on every state entry.

Reset
- REQ-024 While reset_n=0, all outputs, key states, the toggle register, the pending flag and the counter are 0, and the FSM is in IDLE.
- REQ-025 Reset asserted mid-pulse drops btn_coin asynchronously; after release, no pulse occurs until a new 0->1 of coin_src.

Verification (COIN_PULSE=4, COIN_GAP=3)
- REQ-026 ps2_key toggles with {pressed=1, ext=1, code=0x6B}, no_rotate=0 -> btn_left=1 two cycles later; toggle with pressed=0 -> btn_left=0 two cycles later.
- REQ-027 no_rotate=1, joystick_1[2]=1 -> btn_left=1 after one cycle; joystick_1[1]=1 alone -> btn_left stays 0.
- REQ-028 Keyboard code 0x2E held pressed -> btn_coin high for exactly 4 cycles, then low and stays low while the key is held.
- REQ-029 joystick_0[8] pulses twice during PULSE -> exactly two pulses: 4 high, 3 low, 4 high; the second request is dropped.
- REQ-030 Code 0x29 with ext=1 -> btn_fire stays 0; unknown code 0x55 -> no output changes.
- REQ-031 reset_n driven low in the 2nd PULSE cycle -> btn_coin=0 immediately; after release with coin_src still high, btn_coin stays 0.
